// File: rtl/ipml_fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: FSM encoding and a
// constant-safe ceil(log2) helper for sizing counters and pointers.
package ipml_fifo_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/ipml_fifo_rd_obuf.sv
// Small circular output buffer: head entry drives the stream, clear empties it
// in one cycle. A push and a pop together leave the count unchanged.
module ipml_fifo_rd_obuf
  import ipml_fifo_pkg::*;
#(
  parameter int c_DATA_WIDTH = 16,
  parameter int c_BUF_DEPTH  = 4,
  parameter int c_CNT_W      = clog2(c_BUF_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [c_DATA_WIDTH-1:0] din,
  input  logic                    pop,
  input  logic                    clr,
  output logic [c_DATA_WIDTH-1:0] dout,
  output logic                    valid,
  output logic [c_CNT_W-1:0]      cnt
);

  localparam int c_PTR_W = clog2(c_BUF_DEPTH);

  logic [c_DATA_WIDTH-1:0] mem_q [c_BUF_DEPTH];
  logic [c_DATA_WIDTH-1:0] mem_d [c_BUF_DEPTH];
  logic [c_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]      cnt_q, cnt_d;
  logic                    pop_ok;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(c_BUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign valid  = (cnt_q != '0);
  assign pop_ok = pop & valid;
  assign dout   = valid ? mem_q[rd_ptr_q] : '0;
  assign cnt    = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop_ok)      cnt_d = cnt_q + c_CNT_W'(1);
      else if (!push && pop_ok) cnt_d = cnt_q - c_CNT_W'(1);
    end
  end

  // Data storage carries no reset; the count gates what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ipml_fifo_rd_burst_v1_0.sv
// Burst reader: issues FIFO reads under a buffer credit, tracks RAM latency with
// a flag pipe and streams length-counted bursts out as valid/ready.
module ipml_fifo_rd_burst_v1_0
  import ipml_fifo_pkg::*;
#(
  parameter int c_DATA_WIDTH = 16,
  parameter int c_LEN_WIDTH  = 12,
  parameter int c_RD_LATENCY = 1,
  parameter int c_BUF_DEPTH  = 4
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic                    burst_start,
  input  logic [c_LEN_WIDTH-1:0]  burst_len,
  input  logic                    burst_abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    r_en,
  input  logic                    rempty,
  input  logic [c_DATA_WIDTH-1:0] rd_data,
  output logic                    m_valid,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  input  logic                    m_ready
);

  localparam int c_CNT_W = clog2(c_BUF_DEPTH + 1);

  logic [1:0]              state_q, state_d;
  logic [c_LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [c_LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [c_RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                    zdone_q, zdone_d;
  logic                    abrt_q, abrt_d;
  logic [c_CNT_W-1:0]      inflight;
  logic [c_CNT_W-1:0]      buf_cnt;
  logic                    credit_ok, in_run, xfer, buf_push, buf_clr;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < c_RD_LATENCY; i++) inflight = inflight + c_CNT_W'(pipe_q[i]);
  end

  // Reserve a buffer slot for every read still in the RAM pipe.
  assign credit_ok = ({1'b0, inflight} + {1'b0, buf_cnt}) < (c_CNT_W + 1)'(c_BUF_DEPTH);
  assign in_run    = (state_q == ST_RUN);
  assign r_en      = in_run & ~burst_abort & ~rempty & (issue_cnt_q != '0) & credit_ok;
  assign xfer      = m_valid & m_ready;
  assign buf_push  = pipe_q[c_RD_LATENCY-1] & in_run & ~burst_abort;
  assign buf_clr   = in_run & burst_abort;
  assign m_last    = m_valid & (out_cnt_q == c_LEN_WIDTH'(1));

  assign busy    = in_run | (state_q == ST_FLUSH);
  assign done    = (state_q == ST_DONE) | zdone_q;
  assign aborted = (state_q == ST_DONE) & abrt_q;

  ipml_fifo_rd_obuf #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_BUF_DEPTH  (c_BUF_DEPTH),
    .c_CNT_W      (c_CNT_W)
  ) u_obuf (
    .clk   (rclk),
    .rst_n (rrst_n),
    .push  (buf_push),
    .din   (rd_data),
    .pop   (xfer),
    .clr   (buf_clr),
    .dout  (m_data),
    .valid (m_valid),
    .cnt   (buf_cnt)
  );

  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = r_en;
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    zdone_d     = 1'b0;
    abrt_d      = abrt_q;
    case (state_q)
      ST_IDLE: begin
        if (burst_start) begin
          abrt_d = 1'b0;
          if (burst_len != '0) begin
            state_d     = ST_RUN;
            issue_cnt_d = burst_len;
            out_cnt_d   = burst_len;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (r_en) issue_cnt_d = issue_cnt_q - c_LEN_WIDTH'(1);
        if (burst_abort) begin
          state_d = ST_FLUSH;
          abrt_d  = 1'b1;
        end else if (xfer) begin
          if (out_cnt_q != '0) out_cnt_d = out_cnt_q - c_LEN_WIDTH'(1);
          if (m_last) state_d = ST_DONE;
        end
      end
      ST_FLUSH: begin
        if (inflight == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      pipe_q      <= '0;
      zdone_q     <= 1'b0;
      abrt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      pipe_q      <= pipe_d;
      zdone_q     <= zdone_d;
      abrt_q      <= abrt_d;
    end
  end

endmodule
